// File: rtl/mux_n_stream.sv
// Purpose: N:1 stream multiplexer. Sel picks one input channel. Accepted words leave through a registered
//          valid/ready stage with a 2-entry skid buffer, and each word is tagged with the index of its source channel.
// Latency: 1 cycle from accept to o_OutValid when the stage is empty. Full throughput when o_OutReady stays high.
// Backpressure: once both entries hold a word, every o_InReady bit drops. o_MuxOut/o_MuxSrc hold stable while stalled.
// Ports:
//   i_Clock, i_Reset              rising-edge clock, synchronous active-high reset
//   i_MuxIn, i_InValid, o_InReady packed channel data (channel k at [k*NrOfBits +: NrOfBits]) and per-channel handshake
//   i_Sel                         channel select, sampled every cycle
//   o_MuxOut, o_MuxSrc            registered output word and the channel index it came from
//   o_OutValid, i_OutReady        output handshake
//   o_SelErr                      registered flag: i_Sel was out of range in the previous cycle
module mux_n_stream #(
  parameter int NrOfBits   = 32,
  parameter int NrOfInputs = 4,
  parameter int SelBits    = 2
) (
  input  logic                            i_Clock,
  input  logic                            i_Reset,
  input  logic [NrOfInputs*NrOfBits-1:0]  i_MuxIn,
  input  logic [NrOfInputs-1:0]           i_InValid,
  output logic [NrOfInputs-1:0]           o_InReady,
  input  logic [SelBits-1:0]              i_Sel,
  output logic [NrOfBits-1:0]             o_MuxOut,
  output logic [SelBits-1:0]              o_MuxSrc,
  output logic                            o_OutValid,
  input  logic                            i_OutReady,
  output logic                            o_SelErr
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                r_state;
  logic [NrOfBits-1:0]   r_main_dat;
  logic [SelBits-1:0]    r_main_src;
  logic [NrOfBits-1:0]   r_skid_dat;
  logic [SelBits-1:0]    r_skid_src;
  logic                  r_out_vld;
  logic                  r_sel_err;

  logic [31:0]           w_sel_ext;
  logic                  w_sel_ok;
  logic                  w_sel_vld;
  logic [NrOfBits-1:0]   w_sel_dat;
  logic                  w_accept;
  logic                  w_out_xfer;

  // Widen Sel before comparing it, so that NrOfInputs == 2**SelBits cannot overflow the comparison.
  assign w_sel_ext = 32'(i_Sel);
  assign w_sel_ok  = (w_sel_ext < 32'(NrOfInputs));

  // At most one channel can match Sel. An out-of-range Sel matches no channel, which leaves every ready low.
  // Ready is built only from Sel and the state, never from valid.
  always_comb begin
    o_InReady = '0;
    w_sel_vld = 1'b0;
    w_sel_dat = '0;
    for (int k = 0; k < NrOfInputs; k++) begin
      if (w_sel_ext == 32'(k)) begin
        o_InReady[k] = (r_state != FULL);
        w_sel_vld    = i_InValid[k];
        w_sel_dat    = i_MuxIn[k*NrOfBits +: NrOfBits];
      end
    end
  end

  assign w_accept   = w_sel_ok && w_sel_vld && (r_state != FULL);
  assign w_out_xfer = r_out_vld && i_OutReady;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state    <= EMPTY;
      r_main_dat <= '0;
      r_main_src <= '0;
      r_skid_dat <= '0;
      r_skid_src <= '0;
      r_out_vld  <= 1'b0;
      r_sel_err  <= 1'b0;
    end else begin
      r_sel_err <= !w_sel_ok;
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_main_dat <= w_sel_dat;
            r_main_src <= i_Sel;
            r_out_vld  <= 1'b1;
            r_state    <= ONE;
          end
        end
        ONE: begin
          if (w_accept && w_out_xfer) begin
            r_main_dat <= w_sel_dat;
            r_main_src <= i_Sel;
          end else if (w_accept) begin
            // The consumer is stalled, so the new word parks in the skid entry behind the held main word.
            r_skid_dat <= w_sel_dat;
            r_skid_src <= i_Sel;
            r_state    <= FULL;
          end else if (w_out_xfer) begin
            r_out_vld <= 1'b0;
            r_state   <= EMPTY;
          end
        end
        FULL: begin
          if (w_out_xfer) begin
            r_main_dat <= r_skid_dat;
            r_main_src <= r_skid_src;
            r_state    <= ONE;
          end
        end
        default: begin
          r_out_vld <= 1'b0;
          r_state   <= EMPTY;
        end
      endcase
    end
  end

  assign o_MuxOut   = r_main_dat;
  assign o_MuxSrc   = r_main_src;
  assign o_OutValid = r_out_vld;
  assign o_SelErr   = r_sel_err;

endmodule
